// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 single-bus datapath.
// Holds the control-word layout, ALU function encodings, the XZR index and the status bit positions.
// Contains no logic, so it has no latency and no flow control.
package legv8_pkg;

    localparam int CW_W      = 25;
    localparam int REG_IDX_W = 5;
    localparam int FS_W      = 5;
    localparam int DATA_W    = 64;
    localparam int NUM_REGS  = 32;

    // Control-word bit positions: {SA, SB, DA, RegWrite, MemWrite, FS, Bsel, EN_Mem, EN_ALU}
    localparam int CW_SA_LSB   = 20;
    localparam int CW_SB_LSB   = 15;
    localparam int CW_DA_LSB   = 10;
    localparam int CW_REGWRITE = 9;
    localparam int CW_MEMWRITE = 8;
    localparam int CW_FS_LSB   = 3;
    localparam int CW_BSEL     = 2;
    localparam int CW_EN_MEM   = 1;
    localparam int CW_EN_ALU   = 0;

    // Packed view of the control word; the field order matches the bit positions above.
    typedef struct packed {
        logic [REG_IDX_W-1:0] sa;
        logic [REG_IDX_W-1:0] sb;
        logic [REG_IDX_W-1:0] da;
        logic                 reg_write;
        logic                 mem_write;
        logic [FS_W-1:0]      fs;
        logic                 bsel;
        logic                 en_mem;
        logic                 en_alu;
    } ctrl_t;

    // ALU function select, taken from FS[4:2]; codes 110 and 111 produce 0.
    localparam logic [2:0] FS_AND = 3'b000;
    localparam logic [2:0] FS_OR  = 3'b001;
    localparam logic [2:0] FS_ADD = 3'b010;
    localparam logic [2:0] FS_XOR = 3'b011;
    localparam logic [2:0] FS_SHL = 3'b100;
    localparam logic [2:0] FS_SHR = 3'b101;

    localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

    // status = {V, C, N, Z}
    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/regfile_32x64.sv
// 32x64 register file with two combinational read ports and one write port; R31 is the zero register.
// Reads take zero cycles; a write lands on the next rising clock edge.
// No backpressure; an active-low asynchronous reset clears every entry and holds them at 0.
// Ports: clock, reset (active-low), we/da/wd write port, sa->a and sb->b read ports.
module regfile_32x64
    import legv8_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] da,
    input  logic [DATA_W-1:0]    wd,
    input  logic [REG_IDX_W-1:0] sa,
    input  logic [REG_IDX_W-1:0] sb,
    output logic [DATA_W-1:0]    a,
    output logic [DATA_W-1:0]    b
);

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    // Writes to XZR are dropped; reset wins over a coincident write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (da != XZR_IDX)) begin
            regs[da] <= wd;
        end
    end

    // Force XZR to read 0 regardless of what the storage slot holds.
    assign a = (sa == XZR_IDX) ? '0 : regs[sa];
    assign b = (sb == XZR_IDX) ? '0 : regs[sb];

endmodule

// File: rtl/datapath_legv8.sv
// 64-bit LEGv8 single-bus datapath: register file, ALU and data RAM on one shared tri-state bus.
// ALU result, status and RAM read are combinational; register and RAM writes land on the next rising edge.
// No backpressure; the bus is released (high-Z) whenever neither EN_Mem nor EN_ALU is set.
// Ports: clock, reset (active-low, clears registers), ControlWord (25-bit control),
//        constant (immediate B operand), status {V,C,N,Z}, data (shared 64-bit bus).
module datapath_legv8
    import legv8_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CW_W-1:0]   ControlWord,
    output logic [3:0]        status,
    input  logic [DATA_W-1:0] constant,
    inout  wire  [DATA_W-1:0] data
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    ctrl_t cw;
    assign cw = ctrl_t'(ControlWord);

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    regfile_32x64 regfile (
        .clock (clock),
        .reset (reset),
        .we    (cw.reg_write),
        .da    (cw.da),
        .wd    (data),
        .sa    (cw.sa),
        .sb    (cw.sb),
        .a     (a_reg),
        .b     (b_reg)
    );

    // B operand mux and operand conditioning; inverting either operand also injects carry-in,
    // which turns A + ~B + 1 into subtraction.
    logic [DATA_W-1:0] b_mux;
    logic [DATA_W-1:0] a_c;
    logic [DATA_W-1:0] b_c;
    logic              c0;
    logic [DATA_W:0]   sum;

    assign b_mux = cw.bsel ? constant : b_reg;
    assign a_c   = cw.fs[0] ? ~a_reg : a_reg;
    assign b_c   = cw.fs[1] ? ~b_mux : b_mux;
    assign c0    = cw.fs[0] | cw.fs[1];
    assign sum   = {1'b0, a_c} + {1'b0, b_c} + {{DATA_W{1'b0}}, c0};

    logic [DATA_W-1:0] f;
    logic              carry;
    logic              ovf;

    always_comb begin
        f     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (cw.fs[4:2])
            FS_AND: f = a_c & b_c;
            FS_OR:  f = a_c | b_c;
            FS_ADD: begin
                f     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
                // Overflow: operands agree in sign but the result does not.
                ovf   = (a_c[DATA_W-1] == b_c[DATA_W-1]) && (sum[DATA_W-1] != a_c[DATA_W-1]);
            end
            FS_XOR: f = a_c ^ b_c;
            FS_SHL: f = a_c << b_c[5:0];
            FS_SHR: f = a_c >> b_c[5:0];
            default: f = '0;
        endcase
    end

    always_comb begin
        status       = '0;
        status[ST_V] = ovf;
        status[ST_C] = carry;
        status[ST_N] = f[DATA_W-1];
        status[ST_Z] = (f == '0);
    end

    // Word-addressed data RAM. Not reset; power-up contents come from the target's
    // memory initialisation. Read is combinational, so a read of the address being
    // written shows the old word until the edge.
    logic [DATA_W-1:0]        mem [0:MEM_DEPTH-1];
    logic [MEM_ADDR_BITS-1:0] mem_addr;
    logic [DATA_W-1:0]        mem_rd;

    assign mem_addr = f[MEM_ADDR_BITS-1:0];
    assign mem_rd   = mem[mem_addr];

    // Store data is the raw register B, not the muxed operand, so the immediate can form the address.
    always_ff @(posedge clock) begin
        if (cw.mem_write) begin
            mem[mem_addr] <= b_reg;
        end
    end

    // Memory driver has priority; the ALU driver is disabled when both are enabled.
    assign data = cw.en_mem ? mem_rd :
                  cw.en_alu ? f      : {DATA_W{1'bz}};

endmodule

// File: tb/tb_datapath_legv8.sv
// Directed bench for datapath_legv8: each vector has a hand-computed expected value.
// Registers are observed through the bus by passing R[SA] | XZR through the ALU.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_datapath_legv8;

    logic        clock;
    logic        reset;
    logic [24:0] ControlWord;
    logic [3:0]  status;
    logic [63:0] constant;
    wire  [63:0] data_bus;
    logic [63:0] ext_dat;
    logic        ext_en;

    int n_cmp;
    int n_bad;

    assign data_bus = ext_en ? ext_dat : {64{1'bz}};

    datapath_legv8 #(.MEM_ADDR_BITS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .ControlWord (ControlWord),
        .status      (status),
        .constant    (constant),
        .data        (data_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] mk_cw(input logic [4:0] sa, input logic [4:0] sb,
                                          input logic [4:0] da, input logic rw,
                                          input logic mw, input logic [4:0] fs,
                                          input logic bsel, input logic enm,
                                          input logic ena);
        return {sa, sb, da, rw, mw, fs, bsel, enm, ena};
    endfunction

    // Advance one rising edge and return to the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Write a value into a register from the external bus agent.
    task automatic load_ext(input logic [4:0] r, input logic [63:0] v);
        ext_dat     = v;
        ext_en      = 1'b1;
        ControlWord = mk_cw(5'd0, 5'd0, r, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
        step();
        ext_en      = 1'b0;
    endtask

    // Read a register through the ALU: F = R[r] | XZR, driven onto the bus, no writes.
    task automatic peek(input logic [4:0] r, output logic [63:0] v);
        ControlWord = mk_cw(r, 5'd31, 5'd0, 1'b0, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b1);
        #1;
        v = data_bus;
    endtask

    logic [63:0] v;

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        ext_en      = 1'b0;
        ext_dat     = '0;
        constant    = '0;
        reset       = 1'b0;
        ControlWord = '0;

        // Reset state.
        @(negedge clock);
        peek(5'd0, v);  check("reset_r0", v, 64'd0);
        peek(5'd17, v); check("reset_r17", v, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // Immediate add: R5 = XZR + 4.
        constant    = 64'd4;
        ControlWord = 25'b1111100000001011001000101;
        #1;
        check("imm_add_bus", data_bus, 64'd4);
        check("imm_add_status", {60'd0, status}, 64'h0);
        @(negedge clock);
        peek(5'd5, v); check("imm_add_r5", v, 64'd4);

        // Register add: R5 = R2 + R0 = 6 + 35.
        load_ext(5'd2, 64'd6);
        load_ext(5'd0, 64'd35);
        ControlWord = 25'b0001000000001011001000001;
        step();
        peek(5'd5, v); check("reg_add_r5", v, 64'd41);

        // Asynchronous reset mid-cycle clears registers at once.
        #2;
        reset = 1'b0;
        #1;
        peek(5'd5, v); check("arst_r5", v, 64'd0);
        peek(5'd2, v); check("arst_r2", v, 64'd0);
        // A write attempted while reset is held is lost.
        load_ext(5'd5, 64'h55);
        peek(5'd5, v); check("arst_hold_r5", v, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        // XZR reads 0 and ignores writes.
        peek(5'd31, v); check("xzr_read", v, 64'd0);
        load_ext(5'd31, 64'h1234);
        peek(5'd31, v); check("xzr_write", v, 64'd0);

        // Subtract 5 - 5: F=0, Z=1, C=1.
        load_ext(5'd1, 64'd5);
        load_ext(5'd2, 64'd5);
        ControlWord = mk_cw(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b1);
        #1;
        check("sub_eq_f", data_bus, 64'd0);
        check("sub_eq_status", {60'd0, status}, 64'b0101);
        // 5 - 6: F=all ones, N=1, C=0.
        @(negedge clock);
        load_ext(5'd2, 64'd6);
        ControlWord = mk_cw(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b1);
        #1;
        check("sub_neg_f", data_bus, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_neg_status", {60'd0, status}, 64'b0010);
        // Signed overflow: 0x7FFF..F + 1.
        @(negedge clock);
        load_ext(5'd3, 64'h7FFF_FFFF_FFFF_FFFF);
        constant    = 64'd1;
        ControlWord = mk_cw(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'b01000, 1'b1, 1'b0, 1'b1);
        #1;
        check("ovf_f", data_bus, 64'h8000_0000_0000_0000);
        check("ovf_status", {60'd0, status}, 64'b1010);

        // Store: M[R22 + 0] = R2.
        @(negedge clock);
        load_ext(5'd22, 64'd200);
        load_ext(5'd2, 64'hDEAD);
        constant    = 64'd0;
        ControlWord = mk_cw(5'd22, 5'd2, 5'd0, 1'b0, 1'b1, 5'b01000, 1'b1, 1'b0, 1'b1);
        #1;
        check("store_addr_bus", data_bus, 64'd200);
        @(negedge clock);

        // Load: R28 = M[R22 + 0].
        ControlWord = 25'b1011000000111001001000110;
        #1;
        check("load_bus", data_bus, 64'hDEAD);
        @(negedge clock);
        peek(5'd28, v); check("load_r28", v, 64'hDEAD);

        // Both enables set while overwriting M[200]: bus carries the old RAM word until the
        // edge, and R7 captures it in the same cycle the RAM is written.
        load_ext(5'd2, 64'hBEEF);
        ControlWord = mk_cw(5'd22, 5'd2, 5'd7, 1'b1, 1'b1, 5'b01000, 1'b1, 1'b1, 1'b1);
        #1;
        check("both_en_old", data_bus, 64'hDEAD);
        @(negedge clock);
        ControlWord = mk_cw(5'd22, 5'd2, 5'd0, 1'b0, 1'b0, 5'b01000, 1'b1, 1'b1, 1'b1);
        #1;
        check("both_en_new", data_bus, 64'hBEEF);
        peek(5'd7, v); check("same_cycle_r7", v, 64'hDEAD);

        // Shifts and undefined function.
        @(negedge clock);
        load_ext(5'd1, 64'd1);
        constant    = 64'd63;
        ControlWord = mk_cw(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'b10000, 1'b1, 1'b0, 1'b1);
        #1;
        check("shl63_f", data_bus, 64'h8000_0000_0000_0000);
        check("shl63_status", {60'd0, status}, 64'b0010);
        ControlWord = mk_cw(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'b10100, 1'b1, 1'b0, 1'b1);
        #1;
        check("shr63_f", data_bus, 64'd0);
        ControlWord = mk_cw(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'b11000, 1'b1, 1'b0, 1'b1);
        #1;
        check("undef_f", data_bus, 64'd0);
        check("undef_status", {60'd0, status}, 64'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
